ppu_ri: RTL and testbench
=========================

Name: ppu_ri

Overview:
- CPU-facing register interface of the PPU, decoding $2000-$2007 accesses from the 6502 bus.
- Holds the scroll/nametable "temp" fields that the background fetch stage loads at frame start, and the mask/control bits it consumes.
- Owns the PPUDATA VRAM address, read buffer and OAM address port.
- Arbitrates CPU VRAM accesses against rendering via a one-entry pending slot; generates the vblank NMI.

Parameters:
- INC_BIG, 6'd32, VRAM address increment when control bit 2 is set; otherwise the increment is 1.

Ports:
- clk_in  in  1  100MHz system clock
- rst_in  in  1  reset
- sel_in  in  3  CPU register select (A2..A0)
- ncs_in  in  1  PPU chip select, active low
- r_nw_in  in  1  1=read, 0=write
- cpu_d_in  in  8  CPU write data
- cpu_d_out  out  8  CPU read data
- vblank_in  in  1  high during vblank lines, from timing generator
- spr_ovf_in  in  1  sprite overflow flag
- spr0_hit_in  in  1  sprite 0 hit flag
- vram_busy_in  in  1  rendering owns VRAM bus this cycle
- vram_d_in  in  8  VRAM read data, valid cycle after address
- vram_a_out  out  14  CPU VRAM address
- vram_d_out  out  8  VRAM write data
- vram_wr_out  out  1  VRAM write strobe, 1 cycle
- vram_rd_out  out  1  VRAM read request, 1 cycle
- spr_ram_a_out  out  8  OAM address
- spr_ram_d_out  out  8  OAM write data
- spr_ram_wr_out  out  1  OAM write strobe
- spr_ram_d_in  in  8  OAM read data
- nt_v_out, nt_h_out  out  1 each  temp nametable select
- cv_out  out  5  coarse V
- fv_out  out  3  fine V
- ch_out  out  5  coarse H
- fh_out  out  3  fine H
- bg_pt_sel_out, spr_pt_sel_out, spr_h_out  out  1 each  control bits 4, 3, 5
- bg_en_out, spr_en_out, bg_lt_en_out, spr_lt_en_out  out  1 each  mask bits 3, 4, 1, 2
- nvbl_out  out  1  NMI, active low

Behaviour:
- Reset: rst_in asynchronous, active-low; clock clk_in.
- Reset values: all registers and outputs 0, except nvbl_out=1. This includes the toggle, address, buffer and pending slot.
- Access detect: ncs_in is registered. An access executes exactly once, on the first clk where ncs_in=0 and the previous ncs_in=1. A long low period never repeats the access.
- $2000 write: nt_v=d[1], nt_h=d[0], inc32=d[2], spr_pt_sel=d[3], bg_pt_sel=d[4], spr_h=d[5], nvbl_en=d[7].
- $2001 write: stores mask bits.
- $2002 read:
  - cpu_d_out={vbl_flag, spr0_hit_in, spr_ovf_in, 5'b0}.
  - Then clears vbl_flag and the write toggle.
- $2003 write: OAM addr = d.
- $2004 write: OAM write strobe at the current address, then address+1 (wraps 8'hFF to 8'h00).
- $2004 read: returns spr_ram_d_in; no increment.
- $2005 write:
  - toggle 0: ch=d[7:3], fh=d[2:0].
  - toggle 1: cv=d[7:3], fv=d[2:0].
  - Toggle flips after each write.
- $2006 write:
  - toggle 0: fv={1'b0,d[5:4]}, nt_v=d[3], nt_h=d[2], cv[4:3]=d[1:0].
  - toggle 1: cv[2:0]=d[7:5], ch=d[4:0], and vaddr <= {fv,nt_v,nt_h,cv,ch} with the new values.
  - Toggle is shared with $2005.
- $2007 write: enqueues a write of d at vaddr.
- $2007 read:
  - cpu_d_out = read buffer (if vaddr[13:8]==6'h3F, the palette data fetched next cycle instead).
  - Enqueues a buffer refill at vaddr.
- Pending slot:
  - Issues when vram_busy_in=0, in the same cycle if already free; otherwise holds until free.
  - Issue drives vram_a_out=vaddr plus vram_wr_out or vram_rd_out for 1 cycle.
  - A read captures vram_d_in into the buffer on the following cycle.
  - After issue, vaddr += (inc32 ? 32 : 1), mod 2^14.
  - A new $2007 access while a pending one exists is dropped; the CPU cycle is far slower, so this is not expected.
- vbl_flag:
  - Set on vblank_in rising edge; cleared on vblank_in falling edge or on a $2002 read.
  - If the set and a $2002 read land in the same cycle, the set wins and the read returns bit7=0.
- nvbl_out = ~(vbl_flag & nvbl_en), registered. Setting nvbl_en while vbl_flag=1 asserts NMI the next cycle.
- Reset mid-access: pending access is discarded; no strobe.

Test Plan:
- Write $2006=8'h21 then $2006=8'h08 -> vaddr=14'h2108. Then write $2007=8'h55 -> one-cycle vram_wr_out with a=14'h2108, d=8'h55; vaddr becomes 14'h2109.
- Set $2000=8'h04, vaddr=14'h3FFF, write $2007 -> vaddr wraps to 14'h001F. Hold vram_busy_in=1 for 10 cycles -> strobe delayed exactly until busy drops.
- Preload VRAM 14'h2000=8'hAA, 14'h2001=8'hBB; set vaddr=14'h2000; read $2007 twice -> first returns stale buffer (8'h00 after reset), second returns 8'hAA. Palette read at 14'h3F00 returns palette data directly.
- Write $2005=8'h7D, 8'h5E -> ch=5'h0F, fh=3'h5, cv=5'h0B, fv=3'h6. A $2002 read between the writes resets the toggle, so the second write targets ch/fh again.
- Raise vblank_in with $2000 bit7=1 -> nvbl_out=0 next cycle. Read $2002 -> returns 8'h80 and nvbl_out returns to 1. Read coinciding with the vblank_in rise -> returns bit7=0 and the flag stays set.
- Hold ncs_in low for 50 cycles on a $2004 write -> exactly one OAM write strobe. OAM address 8'hFF advances to 8'h00.

Source files
------------

// File: rtl/ppu_ri.sv
// PPU CPU register interface: $2000-$2007 decode, scroll/VRAM address state,
// PPUDATA read buffer with a one-entry VRAM access slot, OAM port and vblank NMI.
module ppu_ri #(
    parameter logic [5:0] INC_BIG = 6'd32
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [2:0]  sel_in,
    input  logic        ncs_in,
    input  logic        r_nw_in,
    input  logic [7:0]  cpu_d_in,
    output logic [7:0]  cpu_d_out,
    input  logic        vblank_in,
    input  logic        spr_ovf_in,
    input  logic        spr0_hit_in,
    input  logic        vram_busy_in,
    input  logic [7:0]  vram_d_in,
    output logic [13:0] vram_a_out,
    output logic [7:0]  vram_d_out,
    output logic        vram_wr_out,
    output logic        vram_rd_out,
    output logic [7:0]  spr_ram_a_out,
    output logic [7:0]  spr_ram_d_out,
    output logic        spr_ram_wr_out,
    input  logic [7:0]  spr_ram_d_in,
    output logic        nt_v_out,
    output logic        nt_h_out,
    output logic [4:0]  cv_out,
    output logic [2:0]  fv_out,
    output logic [4:0]  ch_out,
    output logic [2:0]  fh_out,
    output logic        bg_pt_sel_out,
    output logic        spr_pt_sel_out,
    output logic        spr_h_out,
    output logic        bg_en_out,
    output logic        spr_en_out,
    output logic        bg_lt_en_out,
    output logic        spr_lt_en_out,
    output logic        nvbl_out
);

    logic        ncs_q_reg;
    logic        vblank_q_reg;
    logic        vbl_flag_reg;
    logic        nvbl_en_reg;
    logic        inc32_reg;
    logic        toggle_reg;
    logic [13:0] vaddr_reg;
    logic [7:0]  rd_buf_reg;
    logic        pend_valid_reg;
    logic        pend_wr_reg;
    logic        pend_pal_reg;
    logic [7:0]  pend_d_reg;
    logic        rd_pal_reg;
    logic        rd_d1_reg;
    logic        rd_d1_pal_reg;

    logic        acc;
    logic        wr_acc;
    logic        rd_acc;
    logic        new_req;
    logic        issue;
    logic        req_wr;
    logic        req_pal;
    logic [7:0]  req_d;
    logic [13:0] vaddr_inc;
    logic        vbl_rise;
    logic        vbl_fall;
    logic        pal_now;

    always_comb begin
        // an access fires only on the high-to-low transition of chip select
        acc       = ~ncs_in & ncs_q_reg;
        wr_acc    = acc & ~r_nw_in;
        rd_acc    = acc & r_nw_in;
        pal_now   = (vaddr_reg[13:8] == 6'h3F);
        new_req   = acc && (sel_in == 3'd7) && !pend_valid_reg;
        issue     = (pend_valid_reg | new_req) & ~vram_busy_in;
        req_wr    = pend_valid_reg ? pend_wr_reg  : ~r_nw_in;
        req_d     = pend_valid_reg ? pend_d_reg   : cpu_d_in;
        req_pal   = pend_valid_reg ? pend_pal_reg : pal_now;
        vaddr_inc = vaddr_reg + (inc32_reg ? {8'd0, INC_BIG} : 14'd1);
        vbl_rise  = vblank_in & ~vblank_q_reg;
        vbl_fall  = ~vblank_in & vblank_q_reg;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ncs_q_reg      <= 1'b0;
            vblank_q_reg   <= 1'b0;
            vbl_flag_reg   <= 1'b0;
            nvbl_en_reg    <= 1'b0;
            inc32_reg      <= 1'b0;
            toggle_reg     <= 1'b0;
            vaddr_reg      <= 14'd0;
            rd_buf_reg     <= 8'd0;
            pend_valid_reg <= 1'b0;
            pend_wr_reg    <= 1'b0;
            pend_pal_reg   <= 1'b0;
            pend_d_reg     <= 8'd0;
            rd_pal_reg     <= 1'b0;
            rd_d1_reg      <= 1'b0;
            rd_d1_pal_reg  <= 1'b0;
            cpu_d_out      <= 8'd0;
            vram_a_out     <= 14'd0;
            vram_d_out     <= 8'd0;
            vram_wr_out    <= 1'b0;
            vram_rd_out    <= 1'b0;
            spr_ram_a_out  <= 8'd0;
            spr_ram_d_out  <= 8'd0;
            spr_ram_wr_out <= 1'b0;
            nt_v_out       <= 1'b0;
            nt_h_out       <= 1'b0;
            cv_out         <= 5'd0;
            fv_out         <= 3'd0;
            ch_out         <= 5'd0;
            fh_out         <= 3'd0;
            bg_pt_sel_out  <= 1'b0;
            spr_pt_sel_out <= 1'b0;
            spr_h_out      <= 1'b0;
            bg_en_out      <= 1'b0;
            spr_en_out     <= 1'b0;
            bg_lt_en_out   <= 1'b0;
            spr_lt_en_out  <= 1'b0;
            nvbl_out       <= 1'b1;
        end else begin
            ncs_q_reg      <= ncs_in;
            vblank_q_reg   <= vblank_in;
            vram_wr_out    <= 1'b0;
            vram_rd_out    <= 1'b0;
            rd_pal_reg     <= 1'b0;
            spr_ram_wr_out <= 1'b0;
            nvbl_out       <= ~(vbl_flag_reg & nvbl_en_reg);

            // OAM address advances after the strobe so the write sees the old address
            if (spr_ram_wr_out)
                spr_ram_a_out <= spr_ram_a_out + 8'd1;

            if (vbl_rise)
                vbl_flag_reg <= 1'b1;
            else if (vbl_fall || (rd_acc && sel_in == 3'd2))
                vbl_flag_reg <= 1'b0;

            rd_d1_reg     <= vram_rd_out;
            rd_d1_pal_reg <= rd_pal_reg;
            if (rd_d1_reg) begin
                rd_buf_reg <= vram_d_in;
                if (rd_d1_pal_reg)
                    cpu_d_out <= vram_d_in;
            end

            if (issue) begin
                vram_a_out     <= vaddr_reg;
                vram_wr_out    <= req_wr;
                vram_rd_out    <= ~req_wr;
                rd_pal_reg     <= ~req_wr & req_pal;
                if (req_wr)
                    vram_d_out <= req_d;
                vaddr_reg      <= vaddr_inc;
                pend_valid_reg <= 1'b0;
            end else if (new_req) begin
                pend_valid_reg <= 1'b1;
                pend_wr_reg    <= ~r_nw_in;
                pend_d_reg     <= cpu_d_in;
                pend_pal_reg   <= pal_now;
            end

            if (wr_acc) begin
                case (sel_in)
                    3'd0: begin
                        nt_h_out       <= cpu_d_in[0];
                        nt_v_out       <= cpu_d_in[1];
                        inc32_reg      <= cpu_d_in[2];
                        spr_pt_sel_out <= cpu_d_in[3];
                        bg_pt_sel_out  <= cpu_d_in[4];
                        spr_h_out      <= cpu_d_in[5];
                        nvbl_en_reg    <= cpu_d_in[7];
                    end
                    3'd1: begin
                        bg_lt_en_out  <= cpu_d_in[1];
                        spr_lt_en_out <= cpu_d_in[2];
                        bg_en_out     <= cpu_d_in[3];
                        spr_en_out    <= cpu_d_in[4];
                    end
                    3'd3: spr_ram_a_out <= cpu_d_in;
                    3'd4: begin
                        spr_ram_wr_out <= 1'b1;
                        spr_ram_d_out  <= cpu_d_in;
                    end
                    3'd5: begin
                        if (!toggle_reg) begin
                            ch_out <= cpu_d_in[7:3];
                            fh_out <= cpu_d_in[2:0];
                        end else begin
                            cv_out <= cpu_d_in[7:3];
                            fv_out <= cpu_d_in[2:0];
                        end
                        toggle_reg <= ~toggle_reg;
                    end
                    3'd6: begin
                        if (!toggle_reg) begin
                            fv_out      <= {1'b0, cpu_d_in[5:4]};
                            nt_v_out    <= cpu_d_in[3];
                            nt_h_out    <= cpu_d_in[2];
                            cv_out[4:3] <= cpu_d_in[1:0];
                        end else begin
                            cv_out[2:0] <= cpu_d_in[7:5];
                            ch_out      <= cpu_d_in[4:0];
                            // the second write overrides any same-cycle post-issue increment
                            vaddr_reg   <= {fv_out[1:0], nt_v_out, nt_h_out, cv_out[4:3],
                                            cpu_d_in[7:5], cpu_d_in[4:0]};
                        end
                        toggle_reg <= ~toggle_reg;
                    end
                    default: ;
                endcase
            end

            if (rd_acc) begin
                case (sel_in)
                    3'd2: begin
                        cpu_d_out  <= {vbl_flag_reg, spr0_hit_in, spr_ovf_in, 5'b0};
                        toggle_reg <= 1'b0;
                    end
                    3'd4: cpu_d_out <= spr_ram_d_in;
                    // palette reads bypass the buffer and load when the fetch returns
                    3'd7: if (!pal_now) cpu_d_out <= rd_buf_reg;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppu_ri.sv
// Directed bench for ppu_ri: drives 6502-style register accesses against a
// small VRAM model and checks hand-computed results.
module tb_ppu_ri;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [2:0]  sel_in = 3'd0;
    logic        ncs_in = 1'b1;
    logic        r_nw_in = 1'b1;
    logic [7:0]  cpu_d_in = 8'd0;
    logic [7:0]  cpu_d_out;
    logic        vblank_in = 1'b0;
    logic        spr_ovf_in = 1'b0;
    logic        spr0_hit_in = 1'b0;
    logic        vram_busy_in = 1'b0;
    logic [7:0]  vram_d_in = 8'd0;
    logic [13:0] vram_a_out;
    logic [7:0]  vram_d_out;
    logic        vram_wr_out;
    logic        vram_rd_out;
    logic [7:0]  spr_ram_a_out;
    logic [7:0]  spr_ram_d_out;
    logic        spr_ram_wr_out;
    logic [7:0]  spr_ram_d_in = 8'h5A;
    logic        nt_v_out, nt_h_out;
    logic [4:0]  cv_out, ch_out;
    logic [2:0]  fv_out, fh_out;
    logic        bg_pt_sel_out, spr_pt_sel_out, spr_h_out;
    logic        bg_en_out, spr_en_out, bg_lt_en_out, spr_lt_en_out;
    logic        nvbl_out;

    int          total = 0;
    int          bad = 0;
    int          wr_cnt = 0;
    int          oam_cnt = 0;
    logic [13:0] last_wa = 14'd0;
    logic [7:0]  last_wd = 8'd0;
    logic [7:0]  last_oa = 8'd0;
    logic [7:0]  last_od = 8'd0;
    logic [7:0]  rd_val;
    logic [7:0]  mem [0:16383];

    ppu_ri dut (
        .clk_in(clk_in), .rst_in(rst_in), .sel_in(sel_in), .ncs_in(ncs_in),
        .r_nw_in(r_nw_in), .cpu_d_in(cpu_d_in), .cpu_d_out(cpu_d_out),
        .vblank_in(vblank_in), .spr_ovf_in(spr_ovf_in), .spr0_hit_in(spr0_hit_in),
        .vram_busy_in(vram_busy_in), .vram_d_in(vram_d_in), .vram_a_out(vram_a_out),
        .vram_d_out(vram_d_out), .vram_wr_out(vram_wr_out), .vram_rd_out(vram_rd_out),
        .spr_ram_a_out(spr_ram_a_out), .spr_ram_d_out(spr_ram_d_out),
        .spr_ram_wr_out(spr_ram_wr_out), .spr_ram_d_in(spr_ram_d_in),
        .nt_v_out(nt_v_out), .nt_h_out(nt_h_out), .cv_out(cv_out), .fv_out(fv_out),
        .ch_out(ch_out), .fh_out(fh_out), .bg_pt_sel_out(bg_pt_sel_out),
        .spr_pt_sel_out(spr_pt_sel_out), .spr_h_out(spr_h_out),
        .bg_en_out(bg_en_out), .spr_en_out(spr_en_out),
        .bg_lt_en_out(bg_lt_en_out), .spr_lt_en_out(spr_lt_en_out),
        .nvbl_out(nvbl_out)
    );

    always #5 clk_in = ~clk_in;

    // VRAM model and strobe monitors, all sampled mid-cycle
    always @(negedge clk_in) begin
        if (vram_rd_out)
            vram_d_in = mem[vram_a_out];
        if (vram_wr_out) begin
            mem[vram_a_out] = vram_d_out;
            wr_cnt++;
            last_wa = vram_a_out;
            last_wd = vram_d_out;
        end
        if (spr_ram_wr_out) begin
            oam_cnt++;
            last_oa = spr_ram_a_out;
            last_od = spr_ram_d_out;
        end
    end

    task automatic bus(input logic [2:0] s, input logic rnw, input logic [7:0] d, input int hold);
        @(negedge clk_in);
        sel_in = s; r_nw_in = rnw; cpu_d_in = d; ncs_in = 1'b0;
        repeat (hold) @(negedge clk_in);
        rd_val = cpu_d_out;
        ncs_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_reset;
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        total++; if (nvbl_out !== 1'b1) begin bad++; $display("FAIL reset_nvbl got=%b exp=1", nvbl_out); end
        total++; if (cpu_d_out !== 8'h00) begin bad++; $display("FAIL reset_cpu_d got=%h exp=00", cpu_d_out); end
        total++; if ({vram_wr_out, vram_rd_out, spr_ram_wr_out} !== 3'b000) begin bad++; $display("FAIL reset_strobes got=%b exp=000", {vram_wr_out, vram_rd_out, spr_ram_wr_out}); end
        total++; if ({cv_out, ch_out, fv_out, fh_out, spr_ram_a_out} !== 24'd0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {cv_out, ch_out, fv_out, fh_out, spr_ram_a_out}); end
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_reset_mid;
        int c0;
        c0 = wr_cnt;
        vram_busy_in = 1'b1;
        bus(3'd7, 1'b0, 8'h11, 1);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        vram_busy_in = 1'b0;
        repeat (5) @(negedge clk_in);
        total++; if (wr_cnt !== c0) begin bad++; $display("FAIL reset_mid_strobe got=%0d exp=%0d", wr_cnt, c0); end
    endtask

    task automatic test_vaddr_write;
        int c0;
        bus(3'd6, 1'b0, 8'h21, 1);
        bus(3'd6, 1'b0, 8'h08, 1);
        total++; if ({cv_out, ch_out, fv_out} !== {5'h08, 5'h08, 3'h2}) begin bad++; $display("FAIL vaddr_fields got=%h exp=%h", {cv_out, ch_out, fv_out}, {5'h08, 5'h08, 3'h2}); end
        c0 = wr_cnt;
        bus(3'd7, 1'b0, 8'h55, 1);
        total++; if (wr_cnt !== c0 + 1) begin bad++; $display("FAIL wr_strobe_cnt got=%0d exp=%0d", wr_cnt, c0 + 1); end
        total++; if (last_wa !== 14'h2108 || last_wd !== 8'h55) begin bad++; $display("FAIL wr_addr_data got=%h/%h exp=2108/55", last_wa, last_wd); end
        bus(3'd7, 1'b0, 8'h66, 1);
        total++; if (last_wa !== 14'h2109) begin bad++; $display("FAIL wr_inc1 got=%h exp=2109", last_wa); end
    endtask

    task automatic test_inc32_busy;
        int c0;
        logic seen;
        bus(3'd0, 1'b0, 8'h04, 1);
        bus(3'd6, 1'b0, 8'h3F, 1);
        bus(3'd6, 1'b0, 8'hFF, 1);
        c0 = wr_cnt;
        seen = 1'b0;
        vram_busy_in = 1'b1;
        bus(3'd7, 1'b0, 8'h77, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            if (vram_wr_out) seen = 1'b1;
        end
        total++; if (seen !== 1'b0 || wr_cnt !== c0) begin bad++; $display("FAIL busy_hold got=%b/%0d exp=0/%0d", seen, wr_cnt, c0); end
        vram_busy_in = 1'b0;
        @(negedge clk_in);
        total++; if (vram_wr_out !== 1'b1 || vram_a_out !== 14'h3FFF || vram_d_out !== 8'h77) begin bad++; $display("FAIL busy_release got=%b/%h/%h exp=1/3fff/77", vram_wr_out, vram_a_out, vram_d_out); end
        @(negedge clk_in);
        total++; if (vram_wr_out !== 1'b0) begin bad++; $display("FAIL busy_width got=%b exp=0", vram_wr_out); end
        bus(3'd7, 1'b0, 8'h88, 1);
        total++; if (last_wa !== 14'h001F) begin bad++; $display("FAIL inc32_wrap got=%h exp=001f", last_wa); end
        bus(3'd0, 1'b0, 8'h00, 1);
    endtask

    task automatic test_read_buffer;
        bus(3'd6, 1'b0, 8'h20, 1);
        bus(3'd6, 1'b0, 8'h00, 1);
        bus(3'd7, 1'b1, 8'h00, 1);
        total++; if (rd_val !== 8'h00) begin bad++; $display("FAIL rdbuf_stale got=%h exp=00", rd_val); end
        bus(3'd7, 1'b1, 8'h00, 1);
        total++; if (rd_val !== 8'hAA) begin bad++; $display("FAIL rdbuf_first got=%h exp=aa", rd_val); end
        bus(3'd7, 1'b1, 8'h00, 1);
        total++; if (rd_val !== 8'hBB) begin bad++; $display("FAIL rdbuf_second got=%h exp=bb", rd_val); end
        bus(3'd6, 1'b0, 8'h3F, 1);
        bus(3'd6, 1'b0, 8'h00, 1);
        bus(3'd7, 1'b1, 8'h00, 1);
        repeat (2) @(negedge clk_in);
        total++; if (cpu_d_out !== 8'h1C) begin bad++; $display("FAIL palette_read got=%h exp=1c", cpu_d_out); end
    endtask

    task automatic test_scroll;
        bus(3'd5, 1'b0, 8'h7D, 1);
        bus(3'd5, 1'b0, 8'h5E, 1);
        total++; if ({ch_out, fh_out, cv_out, fv_out} !== {5'h0F, 3'h5, 5'h0B, 3'h6}) begin bad++; $display("FAIL scroll_pair got=%h exp=%h", {ch_out, fh_out, cv_out, fv_out}, {5'h0F, 3'h5, 5'h0B, 3'h6}); end
        bus(3'd5, 1'b0, 8'h13, 1);
        bus(3'd2, 1'b1, 8'h00, 1);
        bus(3'd5, 1'b0, 8'hA9, 1);
        total++; if ({ch_out, fh_out, cv_out} !== {5'h15, 3'h1, 5'h0B}) begin bad++; $display("FAIL scroll_toggle_clr got=%h exp=%h", {ch_out, fh_out, cv_out}, {5'h15, 3'h1, 5'h0B}); end
        bus(3'd5, 1'b0, 8'h42, 1);
        total++; if ({cv_out, fv_out} !== {5'h08, 3'h2}) begin bad++; $display("FAIL scroll_second got=%h exp=%h", {cv_out, fv_out}, {5'h08, 3'h2}); end
    endtask

    task automatic test_vblank;
        bus(3'd0, 1'b0, 8'h00, 1);
        @(negedge clk_in); vblank_in = 1'b1;
        repeat (3) @(negedge clk_in);
        total++; if (nvbl_out !== 1'b1) begin bad++; $display("FAIL nmi_disabled got=%b exp=1", nvbl_out); end
        bus(3'd0, 1'b0, 8'h80, 1);
        total++; if (nvbl_out !== 1'b0) begin bad++; $display("FAIL nmi_enable_late got=%b exp=0", nvbl_out); end
        bus(3'd2, 1'b1, 8'h00, 1);
        total++; if (rd_val !== 8'h80) begin bad++; $display("FAIL status_read got=%h exp=80", rd_val); end
        total++; if (nvbl_out !== 1'b1) begin bad++; $display("FAIL nmi_cleared got=%b exp=1", nvbl_out); end
        @(negedge clk_in); vblank_in = 1'b0;
        repeat (3) @(negedge clk_in);
        sel_in = 3'd2; r_nw_in = 1'b1; ncs_in = 1'b0; vblank_in = 1'b1;
        @(negedge clk_in);
        total++; if (cpu_d_out[7] !== 1'b0) begin bad++; $display("FAIL race_bit7 got=%b exp=0", cpu_d_out[7]); end
        ncs_in = 1'b1;
        repeat (2) @(negedge clk_in);
        total++; if (nvbl_out !== 1'b0) begin bad++; $display("FAIL race_nmi got=%b exp=0", nvbl_out); end
        spr0_hit_in = 1'b1;
        bus(3'd2, 1'b1, 8'h00, 1);
        total++; if (rd_val !== 8'hC0) begin bad++; $display("FAIL race_flag_kept got=%h exp=c0", rd_val); end
        spr0_hit_in = 1'b0;
        vblank_in = 1'b0;
        bus(3'd0, 1'b0, 8'h00, 1);
    endtask

    task automatic test_oam;
        int c0;
        bus(3'd3, 1'b0, 8'hFF, 1);
        c0 = oam_cnt;
        bus(3'd4, 1'b0, 8'h3C, 50);
        total++; if (oam_cnt !== c0 + 1) begin bad++; $display("FAIL oam_once got=%0d exp=%0d", oam_cnt, c0 + 1); end
        total++; if (last_oa !== 8'hFF || last_od !== 8'h3C) begin bad++; $display("FAIL oam_addr_data got=%h/%h exp=ff/3c", last_oa, last_od); end
        total++; if (spr_ram_a_out !== 8'h00) begin bad++; $display("FAIL oam_wrap got=%h exp=00", spr_ram_a_out); end
        bus(3'd4, 1'b1, 8'h00, 1);
        total++; if (rd_val !== 8'h5A || spr_ram_a_out !== 8'h00) begin bad++; $display("FAIL oam_read got=%h/%h exp=5a/00", rd_val, spr_ram_a_out); end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[14'h2000] = 8'hAA;
        mem[14'h2001] = 8'hBB;
        mem[14'h3F00] = 8'h1C;
        test_reset;
        test_reset_mid;
        test_vaddr_write;
        test_inc32_busy;
        test_read_buffer;
        test_scroll;
        test_vblank;
        test_oam;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
